// File: rtl/fft_output_serializer.sv
// Ping/pong frame buffer that turns one 4-bin complex FFT result per strobe into a
// valid/ready stream of single samples, bin 0 first, with sticky drop detection.
module fft_output_serializer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_real0,
    input  logic [DATA_W-1:0] in_real1,
    input  logic [DATA_W-1:0] in_real2,
    input  logic [DATA_W-1:0] in_real3,
    input  logic [DATA_W-1:0] in_imag0,
    input  logic [DATA_W-1:0] in_imag1,
    input  logic [DATA_W-1:0] in_imag2,
    input  logic [DATA_W-1:0] in_imag3,
    input  logic              out_ready,
    input  logic              clr_overflow,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [1:0]        out_index,
    output logic              out_last,
    output logic              overflow,
    output logic [7:0]        frame_count,
    output logic              fsm_state
);

    // Output handshake: a sample moves on a rising edge where out_valid and
    // out_ready are both 1; while out_ready is 0 every output field holds.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] slot_real [2][4];
    logic [DATA_W-1:0] slot_imag [2][4];
    logic [1:0]        full, full_next;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        rd_idx;
    logic              xfer, last_xfer, capture, drop;

    always_comb begin
        xfer      = (state == STREAM) && out_ready;
        last_xfer = xfer && (rd_idx == 2'd3);
        // A full write slot is only reusable when it is the slot being freed this edge.
        capture   = in_valid && (!full[wr_ptr] || (last_xfer && (wr_ptr == rd_ptr)));
        drop      = in_valid && !capture;
        full_next = full;
        if (last_xfer) full_next[rd_ptr] = 1'b0;
        if (capture)   full_next[wr_ptr] = 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = STREAM;
            STREAM:  if (last_xfer && !full_next[~rd_ptr]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            full        <= 2'b00;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            rd_idx      <= 2'd0;
            overflow    <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state <= state_next;
            full  <= full_next;
            if (capture) wr_ptr <= ~wr_ptr;
            if (xfer) begin
                rd_idx <= rd_idx + 2'd1;
                if (last_xfer) begin
                    rd_ptr      <= ~rd_ptr;
                    frame_count <= frame_count + 8'd1;
                end
            end
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            slot_real[wr_ptr][0] <= in_real0;
            slot_real[wr_ptr][1] <= in_real1;
            slot_real[wr_ptr][2] <= in_real2;
            slot_real[wr_ptr][3] <= in_real3;
            slot_imag[wr_ptr][0] <= in_imag0;
            slot_imag[wr_ptr][1] <= in_imag1;
            slot_imag[wr_ptr][2] <= in_imag2;
            slot_imag[wr_ptr][3] <= in_imag3;
        end
    end

    assign out_valid = (state == STREAM);
    assign out_real  = out_valid ? slot_real[rd_ptr][rd_idx] : '0;
    assign out_imag  = out_valid ? slot_imag[rd_ptr][rd_idx] : '0;
    assign out_index = rd_idx;
    assign out_last  = out_valid && (rd_idx == 2'd3);
    assign fsm_state = state;

endmodule

// File: tb/tb_fft_output_serializer.sv
// Directed bench for fft_output_serializer: reset, single frame, backpressure,
// back-to-back frames, overflow set/clear, free+capture collision, mid-stream reset.
module tb_fft_output_serializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready, clr_overflow;
    logic [W-1:0] in_real0, in_real1, in_real2, in_real3;
    logic [W-1:0] in_imag0, in_imag1, in_imag2, in_imag3;
    logic         out_valid, out_last, overflow, fsm_state;
    logic [W-1:0] out_real, out_imag;
    logic [1:0]   out_index;
    logic [7:0]   frame_count;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_fc  = 0;

    fft_output_serializer #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_real0(in_real0), .in_real1(in_real1), .in_real2(in_real2), .in_real3(in_real3),
        .in_imag0(in_imag0), .in_imag1(in_imag1), .in_imag2(in_imag2), .in_imag3(in_imag3),
        .out_ready(out_ready), .clr_overflow(clr_overflow),
        .out_valid(out_valid), .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_last(out_last), .overflow(overflow),
        .frame_count(frame_count), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs set before the call apply at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bin i of a frame with base b carries (b+i, -(b+i)).
    function automatic logic [W-1:0] re_of(input int b, input int i);
        return W'(b + i);
    endfunction

    function automatic logic [W-1:0] im_of(input int b, input int i);
        return W'(-(b + i));
    endfunction

    task automatic load_frame(input int b);
        in_real0 = re_of(b, 0); in_real1 = re_of(b, 1);
        in_real2 = re_of(b, 2); in_real3 = re_of(b, 3);
        in_imag0 = im_of(b, 0); in_imag1 = im_of(b, 1);
        in_imag2 = im_of(b, 2); in_imag3 = im_of(b, 3);
        in_valid = 1'b1;
    endtask

    task automatic check_sample(input string tag, input int b, input int i);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_real"},  32'(out_real),  32'(re_of(b, i)));
        check({tag, "_imag"},  32'(out_imag),  32'(im_of(b, i)));
        check({tag, "_index"}, 32'(out_index), 32'(i));
        check({tag, "_last"},  32'(out_last),  32'(i == 3));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'd0);
        check({tag, "_fc"},    32'(frame_count), 32'(exp_fc % 256));
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0; clr_overflow = 1'b0;
        load_frame(500);
        // reset with in_valid high must not capture
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_real",  32'(out_real),  32'd0);
        check("rst_imag",  32'(out_imag),  32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_last",  32'(out_last),  32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
        check("rst_fc",    32'(frame_count), 32'd0);

        // single frame, bins (1,-1)..(4,-4)
        out_ready = 1'b1;
        load_frame(1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_sample("single", 1, i);
            tick();
        end
        exp_fc = 1;
        check_idle("single_end");

        // backpressure 1,0,0,1,...
        begin
            int e = 0;
            int cyc = 0;
            load_frame(10);
            out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            while (e < 4 && cyc < 40) begin
                out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                check_sample("bp", 10, e);
                tick();
                if (out_ready) e++;
                cyc++;
            end
            check("bp_done", 32'(e), 32'd4);
            out_ready = 1'b1;
            exp_fc = 2;
            check_idle("bp_end");
        end

        // back-to-back: second strobe lands on the bin-3 transfer edge
        load_frame(20);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) check_sample("b2b_a", 20, c);
            else       check_sample("b2b_b", 30, c - 4);
            if (c == 3) load_frame(30);
            else        in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        exp_fc = 4;
        check_idle("b2b_end");

        // overflow: three strobes with no drain
        out_ready = 1'b0;
        load_frame(40); tick();
        load_frame(50); tick();
        check("ovf_pre", 32'(overflow), 32'd0);
        load_frame(60); tick();
        in_valid = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick();
        check("ovf_clr", 32'(overflow), 32'd0);
        load_frame(70);
        tick();
        in_valid = 1'b0; clr_overflow = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) check_sample("ovf_a", 40, c);
            else       check_sample("ovf_b", 50, c - 4);
            tick();
        end
        exp_fc = 6;
        check_idle("ovf_end");

        // both full, strobe on the bin-3 transfer edge
        out_ready = 1'b0;
        load_frame(80); tick();
        load_frame(90); tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            check_sample("sim", (c < 4) ? 80 : (c < 8) ? 90 : 100, c % 4);
            if (c == 3) load_frame(100);
            else        in_valid = 1'b0;
            tick();
            if (c == 3) check("sim_ovf", 32'(overflow), 32'd0);
        end
        exp_fc = 9;
        check_idle("sim_end");
        check("sim_ovf_end", 32'(overflow), 32'd0);

        // reset after bin 1 transfers
        load_frame(110);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check_sample("mid", 110, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_fc = 0;
        check_idle("mid_rst");
        check("mid_rst_real",  32'(out_real),  32'd0);
        check("mid_rst_index", 32'(out_index), 32'd0);
        check("mid_rst_last",  32'(out_last),  32'd0);
        load_frame(120);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_sample("post_rst", 120, i);
            tick();
        end
        exp_fc = 1;
        check_idle("post_rst_end");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
